// File: rtl/mem_port_arbiter_if.sv
// Bundle between the in-core requesters, the arbiter and the cache port.
// slave: the arbiter's view. master: the side that drives requesters and the cache.
interface mem_port_arbiter_if #(
    parameter int NR_REQ          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NR_REQ-1:0]             req_valid_i;
    logic [NR_REQ-1:0][ADDR_W-1:0] req_addr_i;
    logic [NR_REQ-1:0]             req_ready_o;
    logic [NR_REQ-1:0]             rsp_valid_o;
    logic [DATA_W-1:0]             rsp_data_o;
    logic [NR_REQ-1:0]             rsp_ready_i;
    logic                          mem_req_valid_o;
    logic [ADDR_W-1:0]             mem_req_addr_o;
    logic                          mem_req_ready_i;
    logic                          mem_rsp_valid_i;
    logic [DATA_W-1:0]             mem_rsp_data_i;
    logic                          mem_rsp_ready_o;
    logic [CNT_W-1:0]              outstanding_o;
    logic                          err_o;

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
               mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
               outstanding_o, err_o
    );

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
               mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
               outstanding_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single cache request/response channel.
// An in-order owner FIFO remembers who issued each outstanding request so
// responses are routed back without any ID on the cache side.
//
//   state     | meaning
//   ST_FREE   | grant follows the round-robin scan
//   ST_LOCKED | cache stalled a request; grant held on r_lock_idx
module mem_port_arbiter #(
    parameter int NR_REQ          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.slave  bus
);
    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

    lock_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [IDX_W-1:0] w_rr_pick, w_grant, w_head;
    logic             w_lock, w_any, w_full, w_empty;
    logic             w_mem_req_valid, w_req_hs, w_stall, w_viol;
    logic             w_rsp_hs, w_stray;

    assign w_lock  = (r_state == ST_LOCKED);
    assign w_any   = |bus.req_valid_i;
    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_grant = w_lock ? r_lock_idx : w_rr_pick;
    assign w_head  = r_owner[r_rd_ptr];

    // Full blocks issue even if a pop lands in the same cycle; reset gates everything.
    assign w_mem_req_valid = rstn && (w_any || w_lock) && !w_full;
    assign w_req_hs        = w_mem_req_valid && bus.mem_req_ready_i;
    assign w_stall         = w_mem_req_valid && !bus.mem_req_ready_i;
    assign w_viol          = w_lock && !bus.req_valid_i[r_lock_idx];
    assign w_rsp_hs        = rstn && !w_empty && bus.mem_rsp_valid_i && bus.rsp_ready_i[w_head];
    assign w_stray         = rstn && w_empty && bus.mem_rsp_valid_i;

    // Round-robin scan from r_rr_ptr upward; descending loop leaves the closest hit.
    always_comb begin
        w_rr_pick = r_rr_ptr;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid_i[(int'(r_rr_ptr) + k) % NR_REQ])
                w_rr_pick = IDX_W'((int'(r_rr_ptr) + k) % NR_REQ);
        end
    end

    // Lock state register; the grant index is captured whenever the cache stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_FREE;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall)
                r_lock_idx <= w_grant;
        end
    end

    // Lock next state: a stall locks, a handshake or a dropped locked valid releases.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FREE:   if (w_stall) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_req_hs || w_viol) w_state_nxt = ST_FREE;
            default:   w_state_nxt = ST_FREE;
        endcase
    end

    // Request-side outputs, combinational from requester to cache.
    always_comb begin
        bus.req_ready_o = '0;
        if (w_req_hs)
            bus.req_ready_o[w_grant] = 1'b1;
        bus.mem_req_valid_o = w_mem_req_valid;
        bus.mem_req_addr_o  = bus.req_addr_i[w_grant];
    end

    // Response routing to the FIFO-head owner; stray responses are drained, not routed.
    always_comb begin
        bus.rsp_valid_o = '0;
        if (rstn && !w_empty && bus.mem_rsp_valid_i)
            bus.rsp_valid_o[w_head] = 1'b1;
        bus.mem_rsp_ready_o = rstn && (w_empty ? bus.mem_rsp_valid_i : bus.rsp_ready_i[w_head]);
        bus.rsp_data_o      = bus.mem_rsp_data_i;
        bus.outstanding_o   = rstn ? r_count : '0;
        bus.err_o           = rstn && r_err;
    end

    // Owner FIFO pointers, occupancy, round-robin pointer and sticky error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_grant == IDX_W'(NR_REQ - 1)) ? '0 : w_grant + 1'b1;
            end
            if (w_rsp_hs)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_req_hs, w_rsp_hs})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_stray || w_viol)
                r_err <= 1'b1;
        end
    end

    // Owner storage; stale entries are harmless because r_count qualifies them.
    always_ff @(posedge clk) begin
        if (w_req_hs)
            r_owner[r_wr_ptr] <= w_grant;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int NR_REQ  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NR_REQ(NR_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                          .MAX_OUTSTANDING(MAX_OUT)) bus ();

    mem_port_arbiter #(.NR_REQ(NR_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int  owners[$];
    int  rr_m;
    bit  lock_m;
    int  lock_idx_m;
    bit  err_m;

    // stimulus-side state (requesters and cache)
    bit              pend  [NR_REQ];
    logic [ADDR_W-1:0] paddr [NR_REQ];
    bit              rrdy  [NR_REQ];
    bit              mrdy;
    bit              rsp_hold;
    logic [DATA_W-1:0] rsp_dat;
    int              mem_out;

    logic [63:0] obs_req_ready, obs_rsp_valid, obs_mvalid, obs_maddr;
    logic [63:0] obs_mrr, obs_out, obs_err, obs_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NR_REQ; i++) begin
            bus.req_valid_i[i] = pend[i];
            bus.req_addr_i[i]  = paddr[i];
            bus.rsp_ready_i[i] = rrdy[i];
        end
        bus.mem_req_ready_i = mrdy;
        bus.mem_rsp_valid_i = rsp_hold;
        bus.mem_rsp_data_i  = rsp_dat;
    endtask

    task automatic drive(input int p_req, input int p_mrdy, input int p_rsp, input int p_rrdy);
        @(negedge clk);
        for (int i = 0; i < NR_REQ; i++) begin
            if (!pend[i] && $urandom_range(99) < p_req) begin
                pend[i]  = 1'b1;
                paddr[i] = $urandom;
            end
            rrdy[i] = ($urandom_range(99) < p_rrdy);
        end
        mrdy = ($urandom_range(99) < p_mrdy);
        if (!rsp_hold && mem_out > 0 && $urandom_range(99) < p_rsp) begin
            rsp_hold = 1'b1;
            rsp_dat  = $urandom;
        end
        apply();
    endtask

    task automatic eval_cycle();
        int g, h;
        bit any, found, full, mv, hs, pop, stray;
        logic [NR_REQ-1:0] exp_rr, exp_rv;
        #1;
        any = 1'b0;
        for (int i = 0; i < NR_REQ; i++) if (pend[i]) any = 1'b1;
        g = rr_m;
        if (lock_m) g = lock_idx_m;
        else begin
            found = 1'b0;
            for (int k = 0; k < NR_REQ; k++)
                if (!found && pend[(rr_m + k) % NR_REQ]) begin
                    g = (rr_m + k) % NR_REQ;
                    found = 1'b1;
                end
        end
        full   = (owners.size() == MAX_OUT);
        mv     = (any || lock_m) && !full;
        hs     = mv && mrdy;
        exp_rr = hs ? NR_REQ'(1 << g) : '0;

        obs_req_ready = 64'(bus.req_ready_o);
        obs_rsp_valid = 64'(bus.rsp_valid_o);
        obs_mvalid    = 64'(bus.mem_req_valid_o);
        obs_maddr     = 64'(bus.mem_req_addr_o);
        obs_mrr       = 64'(bus.mem_rsp_ready_o);
        obs_out       = 64'(bus.outstanding_o);
        obs_err       = 64'(bus.err_o);
        obs_data      = 64'(bus.rsp_data_o);

        pop = 1'b0;
        stray = 1'b0;
        if (owners.size() > 0) begin
            h = owners[0];
            exp_rv = rsp_hold ? NR_REQ'(1 << h) : '0;
            chk("mem_rsp_ready", obs_mrr, 64'(rrdy[h]));
            pop = rsp_hold && rrdy[h];
        end else begin
            exp_rv = '0;
            stray = rsp_hold;
            if (rsp_hold) chk("stray_drain", obs_mrr, 64'd1);
        end

        chk("req_ready", obs_req_ready, 64'(exp_rr));
        chk("mem_req_valid", obs_mvalid, 64'(mv));
        if (mv) chk("mem_req_addr", obs_maddr, 64'(paddr[g]));
        chk("rsp_valid", obs_rsp_valid, 64'(exp_rv));
        if (exp_rv != '0) chk("rsp_data", obs_data, 64'(rsp_dat));
        chk("outstanding", obs_out, 64'(owners.size()));
        chk("err", obs_err, 64'(err_m));

        if (pop) begin
            void'(owners.pop_front());
            rsp_hold = 1'b0;
            mem_out--;
        end
        if (stray) begin
            err_m    = 1'b1;
            rsp_hold = 1'b0;
        end
        if (hs) begin
            owners.push_back(g);
            pend[g] = 1'b0;
            mem_out++;
            rr_m   = (g + 1) % NR_REQ;
            lock_m = 1'b0;
        end else if (mv && !mrdy) begin
            lock_m     = 1'b1;
            lock_idx_m = g;
        end
    endtask

    task automatic cycle(input int p_req, input int p_mrdy, input int p_rsp, input int p_rrdy);
        drive(p_req, p_mrdy, p_rsp, p_rrdy);
        eval_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.req_valid_i     = '1;
        bus.mem_req_ready_i = 1'b1;
        bus.mem_rsp_valid_i = 1'b1;
        bus.rsp_ready_i     = '1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_mem_rsp_ready", 64'(bus.mem_rsp_ready_o), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        owners.delete();
        rr_m = 0; lock_m = 1'b0; lock_idx_m = 0; err_m = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; rrdy[i] = 1'b0;
        end
        mrdy = 1'b0; rsp_hold = 1'b0; rsp_dat = '0; mem_out = 0;
        apply();
    endtask

    initial begin
        for (int i = 0; i < NR_REQ; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; rrdy[i] = 1'b0;
        end
        mrdy = 1'b0; rsp_hold = 1'b0; rsp_dat = '0; mem_out = 0;
        apply();

        // single requester
        do_reset();
        pend[0] = 1'b1; paddr[0] = 32'h1000;
        cycle(0, 100, 0, 100);
        chk("t1_grant", obs_req_ready, 64'h1);
        chk("t1_addr", obs_maddr, 64'h1000);
        rsp_hold = 1'b1; rsp_dat = 32'hDEADBEEF;
        cycle(0, 100, 0, 100);
        chk("t1_rsp_valid", obs_rsp_valid, 64'h1);
        chk("t1_rsp_data", obs_data, 64'hDEADBEEF);
        cycle(0, 100, 0, 100);
        chk("t1_outstanding", obs_out, 64'd0);

        // round-robin with in-order responses
        do_reset();
        pend[0] = 1'b1; paddr[0] = 32'hA000;
        pend[1] = 1'b1; paddr[1] = 32'hB000;
        for (int i = 0; i < 6; i++) begin
            cycle(100, 100, 100, 100);
            chk("t2_grant", obs_req_ready, (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) chk("t2_route", obs_rsp_valid, (i % 2 == 1) ? 64'h1 : 64'h2);
        end

        // stall lock
        do_reset();
        pend[1] = 1'b1; paddr[1] = 32'h2222_0000;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 100);
            chk("t3_no_accept", obs_req_ready, 64'h0);
            chk("t3_addr_stable", obs_maddr, 64'h2222_0000);
        end
        pend[0] = 1'b1; paddr[0] = 32'h1111_0000;
        cycle(0, 0, 0, 100);
        chk("t3_lock_held", obs_maddr, 64'h2222_0000);
        cycle(0, 100, 0, 100);
        chk("t3_accept1", obs_req_ready, 64'h2);
        cycle(0, 100, 0, 100);
        chk("t3_accept0", obs_req_ready, 64'h1);

        // owner FIFO full
        do_reset();
        for (int i = 0; i < 6; i++) cycle(100, 100, 0, 100);
        chk("t4_full_count", obs_out, 64'd4);
        chk("t4_full_block", obs_mvalid, 64'd0);
        cycle(100, 100, 100, 100);
        chk("t4_pop_still_block", obs_mvalid, 64'd0);
        cycle(100, 100, 100, 100);
        chk("t4_resume", obs_mvalid, 64'd1);

        // response backpressure
        do_reset();
        pend[1] = 1'b1; paddr[1] = 32'h3000;
        cycle(0, 100, 0, 100);
        rsp_hold = 1'b1; rsp_dat = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 100, 0, 0);
            chk("t5_bp_ready", obs_mrr, 64'd0);
            chk("t5_bp_count", obs_out, 64'd1);
            chk("t5_bp_route", obs_rsp_valid, 64'h2);
        end
        cycle(0, 100, 0, 100);
        chk("t5_release", obs_mrr, 64'd1);
        cycle(0, 100, 0, 100);
        chk("t5_single_pop", obs_out, 64'd0);

        // randomized traffic in three flavours, then reset mid-operation
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0: cycle(70, 80, 60, 80);
                1: cycle(90, 30, 70, 50);
                default: cycle(90, 90, 10, 90);
            endcase
        end
        do_reset();
        for (int i = 0; i < 200; i++) cycle(60, 70, 60, 70);
        do_reset();

        // stray response
        rsp_hold = 1'b1; rsp_dat = 32'hBAD0_0000;
        cycle(0, 100, 0, 100);
        chk("t6_drain", obs_mrr, 64'd1);
        chk("t6_no_route", obs_rsp_valid, 64'h0);
        chk("t6_err_not_yet", obs_err, 64'd0);
        cycle(0, 100, 0, 100);
        chk("t6_err_set", obs_err, 64'd1);
        for (int i = 0; i < 50; i++) cycle(70, 80, 60, 80);
        chk("t6_err_sticky", obs_err, 64'd1);
        do_reset();
        cycle(0, 100, 0, 100);
        chk("t6_err_cleared", obs_err, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
